sel_data_in: RTL and testbench

SEL_DATA_IN -- requirements
Module: sel_data_in

---
 rtl/sel_data_in_if.sv | 25 ++
 rtl/sel_data_in.sv | 122 ++++++++++++
 tb/tb_sel_data_in.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sel_data_in_if.sv
// Beat-in / FIFO-write bus of the channel demultiplexer.
// The bench side drives beats and per-channel full flags; the block drives ready and write strobes.
interface sel_data_in_if #(
  parameter int NUM_CH = 80,
  parameter int DATA_W = 387,
  parameter int CH_W   = 7
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [CH_W-1:0]   chid_in;
  logic              ready_out;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_write_enable;
  logic [DATA_W-1:0] fifo_data_out;

  modport master (
    output valid_in, data_in, chid_in, fifo_full,
    input  ready_out, fifo_write_enable, fifo_data_out
  );

  modport slave (
    input  valid_in, data_in, chid_in, fifo_full,
    output ready_out, fifo_write_enable, fifo_data_out
  );
endinterface

// File: rtl/sel_data_in.sv
// Routes incoming beats to one of NUM_CH channel FIFOs with one cycle of latency,
// checking round-robin channel order, channel range and FIFO-full drops.
module sel_data_in #(
  parameter int NUM_CH = 80,
  parameter int DATA_W = 387,
  parameter int CH_W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  sel_data_in_if.slave bus,
  output logic         seq_err,
  output logic         chid_err,
  output logic [15:0]  drop_count
);

  localparam logic [CH_W:0]   NUM_CH_L = NUM_CH[CH_W:0];
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic              ready;
  logic [CH_W-1:0]   exp_ch;
  logic              accept;
  logic              chid_ok;
  logic              take;
  logic              vld_p0;
  logic [CH_W-1:0]   chid_p0;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] hold_data;
  logic              write;
  logic              drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + CH_W'(1);
  endfunction

  assign accept  = bus.valid_in & ready;
  assign chid_ok = ({1'b0, bus.chid_in} < NUM_CH_L);
  assign take    = accept & chid_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ready  <= 1'b0;
      exp_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state  <= RUN;
            ready  <= 1'b1;
            exp_ch <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            ready <= 1'b0;
          end
          if (take) exp_ch <= next_ch(bus.chid_in);
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out = ready;

  // ---- stage p0: capture accepted in-range beat ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p0 <= 1'b0;
    else      vld_p0 <= take;
  end

  always_ff @(posedge clk) begin
    if (take) begin
      data_p0 <= bus.data_in;
      chid_p0 <= bus.chid_in;
    end
  end

  // ---- write cycle: full flag sampled live, strobe or drop ----
  assign write = vld_p0 & ~bus.fifo_full[chid_p0];
  assign drop  = vld_p0 &  bus.fifo_full[chid_p0];

  assign bus.fifo_write_enable = write ? ({{(NUM_CH-1){1'b0}}, 1'b1} << chid_p0) : '0;
  // Dropped beats must not disturb the bus, so the output falls back to the last written word.
  assign bus.fifo_data_out     = write ? data_p0 : hold_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       hold_data <= '0;
    else if (write) hold_data <= data_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_err    <= 1'b0;
      chid_err   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      seq_err    <= 1'b0;
      chid_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (take && (bus.chid_in != exp_ch)) seq_err  <= 1'b1;
      if (accept && !chid_ok)              chid_err <= 1'b1;
      if (drop)                            drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_sel_data_in.sv
// Scoreboard bench for sel_data_in: expected writes are queued when beats are driven
// and matched against strobes by a per-cycle monitor.
module tb_sel_data_in;
  localparam int NUM_CH = 80;
  localparam int DATA_W = 387;
  localparam int CH_W   = 7;

  typedef struct {
    int                due;
    int                ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        clear;
  logic        seq_err;
  logic        chid_err;
  logic [15:0] drop_count;

  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t q[$];
  logic [DATA_W-1:0] d4;

  sel_data_in_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  sel_data_in #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .bus        (bus),
    .seq_err    (seq_err),
    .chid_err   (chid_err),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: samples 2 time units after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic [NUM_CH-1:0] exp_we;
    #2;
    if (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missed_write ch=%0d due=%0d now=%0d", e.ch, e.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_we = '0;
      exp_we[e.ch] = 1'b1;
      n_chk++;
      if (bus.fifo_write_enable !== exp_we || bus.fifo_data_out !== e.data) begin
        n_fail++;
        $display("FAIL write_ch%0d we=%h exp_we=%h data=%0h exp_data=%0h", e.ch,
                 bus.fifo_write_enable, exp_we, bus.fifo_data_out, e.data);
      end
    end else if (bus.fifo_write_enable !== '0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_strobe we=%h exp=0 cyc=%0d", bus.fifo_write_enable, cyc);
    end
  end

  task automatic send(input int ch, input logic [DATA_W-1:0] d, input bit exp_wr);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.chid_in  = CH_W'(ch);
    bus.data_in  = d;
    if (exp_wr) q.push_back('{cyc + 1, ch, d});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.valid_in = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if (bus.ready_out !== 1'b0 || bus.fifo_write_enable !== '0 || bus.fifo_data_out !== '0 ||
        seq_err !== 1'b0 || chid_err !== 1'b0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state ready=%b we=%h data=%0h seq=%b chid=%b drop=%0d exp all 0",
               bus.ready_out, bus.fifo_write_enable, bus.fifo_data_out, seq_err, chid_err, drop_count);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    n_chk++;
    if (bus.ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset ready=%b exp 0", bus.ready_out);
    end
  endtask

  task automatic test_in_order();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ready ready=%b exp 1", bus.ready_out);
    end
    for (int i = 0; i < NUM_CH; i++) send(i, DATA_W'(i), 1'b1);
    idle(3);
    n_chk++;
    if (seq_err !== 1'b0 || chid_err !== 1'b0 || drop_count !== 16'd0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL in_order_flags seq=%b chid=%b drop=%0d pending=%0d exp 0/0/0/0",
               seq_err, chid_err, drop_count, q.size());
    end
  endtask

  task automatic test_seq_err();
    send(0, DATA_W'(32'hA0), 1'b1);
    send(1, DATA_W'(32'hA1), 1'b1);
    idle(1);
    n_chk++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_ok_0_1 seq_err=%b exp 0", seq_err);
    end
    send(3, DATA_W'(32'hA3), 1'b1);
    idle(1);
    n_chk++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_gap_3 seq_err=%b exp 1", seq_err);
    end
    pulse_clear();
    d4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom};
    send(4, d4, 1'b1);
    idle(2);
    n_chk++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_resync_4 seq_err=%b exp 0", seq_err);
    end
  endtask

  task automatic test_drop();
    bus.fifo_full[5] = 1'b1;
    send(5, DATA_W'(32'hD5), 1'b0);
    idle(1);
    n_chk++;
    if (bus.fifo_data_out !== d4) begin
      n_fail++;
      $display("FAIL hold_on_drop data=%0h exp %0h", bus.fifo_data_out, d4);
    end
    idle(1);
    n_chk++;
    if (drop_count !== 16'd1 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_one drop=%0d seq=%b exp 1/0", drop_count, seq_err);
    end
    for (int i = 0; i < 70000; i++) send(5, DATA_W'(i), 1'b0);
    idle(3);
    n_chk++;
    if (drop_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL drop_saturate drop=%h exp ffff", drop_count);
    end
    // clear lands on the same edge as a drop: clear must win
    send(5, DATA_W'(1), 1'b0);
    pulse_clear();
    n_chk++;
    if (drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_beats_drop drop=%0d exp 0", drop_count);
    end
    bus.fifo_full[5] = 1'b0;
    pulse_clear();
  endtask

  task automatic test_chid_err();
    send(90, DATA_W'(32'hBAD), 1'b0);
    idle(2);
    n_chk++;
    if (chid_err !== 1'b1 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL chid_range chid_err=%b seq=%b exp 1/0", chid_err, seq_err);
    end
    send(6, DATA_W'(32'hC6), 1'b1);
    idle(2);
    n_chk++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_ch_kept seq_err=%b exp 0", seq_err);
    end
    send(9, DATA_W'(32'hC9), 1'b1);
    bus.fifo_full[10] = 1'b1;
    send(10, DATA_W'(32'hCA), 1'b0);
    idle(3);
    bus.fifo_full[10] = 1'b0;
    n_chk++;
    if (seq_err !== 1'b1 || drop_count !== 16'd1 || chid_err !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_clear seq=%b drop=%0d chid=%b exp 1/1/1", seq_err, drop_count, chid_err);
    end
    pulse_clear();
    n_chk++;
    if (seq_err !== 1'b0 || drop_count !== 16'd0 || chid_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_all seq=%b drop=%0d chid=%b exp 0/0/0", seq_err, drop_count, chid_err);
    end
  endtask

  task automatic test_stop();
    send(11, DATA_W'(32'h7B), 1'b1);
    stop = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    stop = 1'b0;
    n_chk++;
    if (bus.ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_ready ready=%b exp 0", bus.ready_out);
    end
    send(0, DATA_W'(32'hEE), 1'b0);
    send(0, DATA_W'(32'hEF), 1'b0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    idle(2);
    n_chk++;
    if (bus.ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle ready=%b exp 0", bus.ready_out);
    end
    stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (bus.ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_ready ready=%b exp 1", bus.ready_out);
    end
    send(0, DATA_W'(32'hF0), 1'b1);
    idle(2);
    n_chk++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_ch_reload seq_err=%b exp 0", seq_err);
    end
  endtask

  task automatic test_reset_midpipe();
    send(2, DATA_W'(32'h55), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    n_chk++;
    if (bus.ready_out !== 1'b0 || bus.fifo_write_enable !== '0 || bus.fifo_data_out !== '0 ||
        seq_err !== 1'b0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_midpipe ready=%b we=%h data=%0h seq=%b drop=%0d exp all 0",
               bus.ready_out, bus.fifo_write_enable, bus.fifo_data_out, seq_err, drop_count);
    end
    bus.valid_in = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(2);
    n_chk++;
    if (bus.ready_out !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL after_midpipe ready=%b pending=%0d exp 0/0", bus.ready_out, q.size());
    end
  endtask

  initial begin
    cyc           = 0;
    n_chk         = 0;
    n_fail        = 0;
    rst           = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    clear         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.chid_in   = '0;
    bus.fifo_full = '0;
    test_reset();
    test_in_order();
    test_seq_err();
    test_drop();
    test_chid_err();
    test_stop();
    test_reset_midpipe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
